// File: rtl/ssb_modulator_if.sv
// SSB modulator sample/result bus.
// The overrun flag exists only when SSB_MOD_OVERRUN_EN is defined.
interface ssb_modulator_if;
    logic [11:0] data_in;
    logic        data_in_valid;
    logic        busy;
    logic [11:0] data_out_i;
    logic [11:0] data_out_q;
    logic        data_out_valid;
`ifdef SSB_MOD_OVERRUN_EN
    logic        overrun;

    modport master (
        output data_in, data_in_valid,
        input  busy, data_out_i, data_out_q, data_out_valid, overrun
    );
    modport slave (
        input  data_in, data_in_valid,
        output busy, data_out_i, data_out_q, data_out_valid, overrun
    );
`else
    modport master (
        output data_in, data_in_valid,
        input  busy, data_out_i, data_out_q, data_out_valid
    );
    modport slave (
        input  data_in, data_in_valid,
        output busy, data_out_i, data_out_q, data_out_valid
    );
`endif
endinterface

// File: rtl/ssb_modulator.sv
// SSB modulator: 7-tap Hilbert FIR (4 nonzero Q8 taps) on a serial MAC,
// one sample per 6 clocks. I is the audio delayed by 3 samples to match
// the Hilbert group delay; Q is the filtered audio, sign set by add_sub.
// Optional sticky overrun flag when SSB_MOD_OVERRUN_EN is defined.
module ssb_modulator #(
    parameter logic add_sub = 1'b1  // 1 = USB, 0 = LSB
) (
    input  logic            clk,
    input  logic            rst,
    ssb_modulator_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t             state, state_nxt;
    logic [1:0]         tap;
    logic [6:0][11:0]   hist;       // hist[0] is the newest sample
    logic signed [23:0] acc;
    logic               busy;
    logic               accept;
    logic               out_vld;
    logic [11:0]        out_i, out_q;

    logic signed [11:0] x_sel;
    logic signed [8:0]  coef;
    logic signed [20:0] prod;
    logic signed [15:0] q_sh;
    logic signed [11:0] q_sat, q_fin;

    assign accept = bus.data_in_valid && !busy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE -> MAC (4 taps) -> OUT -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (tap == 2'd3) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: refuse samples whenever a computation is in flight
    always_comb begin
        busy = (state != IDLE);
    end

    // Tap select: only even taps of the Hilbert kernel are nonzero
    always_comb begin
        x_sel = '0;
        coef  = '0;
        case (tap)
            2'd0: begin x_sel = hist[0]; coef = -9'sd54;  end
            2'd1: begin x_sel = hist[2]; coef = -9'sd163; end
            2'd2: begin x_sel = hist[4]; coef =  9'sd163; end
            2'd3: begin x_sel = hist[6]; coef =  9'sd54;  end
            default: ;
        endcase
    end

    assign prod = x_sel * coef;

    // Q8 -> integer (floor), saturate, then apply sideband sign
    always_comb begin
        q_sh = acc[23:8];   // same bits as acc >>> 8
        if (q_sh > 16'sd2047)
            q_sat = 12'sd2047;
        else if (q_sh < -16'sd2048)
            q_sat = -12'sd2048;
        else
            q_sat = q_sh[11:0];

        if (add_sub)
            q_fin = q_sat;
        else if (q_sat == -12'sd2048)
            q_fin = 12'sd2047;   // -(-2048) does not fit; clamp
        else
            q_fin = -q_sat;
    end

    // Datapath: history shift on accept, MAC, output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist    <= '0;
            acc     <= '0;
            tap     <= '0;
            out_vld <= 1'b0;
            out_i   <= '0;
            out_q   <= '0;
        end else begin
            out_vld <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    hist <= {hist[5:0], bus.data_in};
                    acc  <= '0;
                    tap  <= '0;
                end
                MAC: begin
                    acc <= acc + 24'(prod);
                    tap <= tap + 2'd1;
                end
                OUT: begin
                    // History is frozen while busy, so hist[3] is the
                    // value it had at accept time.
                    out_i   <= hist[3];
                    out_q   <= q_fin;
                    out_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SSB_MOD_OVERRUN_EN
    logic overrun;

    // Sticky: any sample offered while busy is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           overrun <= 1'b0;
        else if (bus.data_in_valid && busy) overrun <= 1'b1;
    end

    assign bus.overrun = overrun;
`endif

    assign bus.busy           = busy;
    assign bus.data_out_i     = out_i;
    assign bus.data_out_q     = out_q;
    assign bus.data_out_valid = out_vld;

endmodule

// File: tb/tb_ssb_modulator.sv
// Bench for ssb_modulator: USB and LSB instances share stimulus; a
// sample-level reference model predicts busy/valid timing and I/Q values.
module tb_ssb_modulator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ssb_modulator_if bus_u ();
    ssb_modulator_if bus_l ();

    ssb_modulator #(.add_sub(1'b1)) dut_u (.clk(clk), .rst(rst), .bus(bus_u));
    ssb_modulator #(.add_sub(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_hist[7];
    int m_busy_left;       // cycles of busy remaining
    int m_vld;
    int m_i, m_qu, m_ql;   // held outputs
    int p_i, p_qu, p_ql;   // result of sample in flight
    int m_ov;

    function automatic int sat12(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic m_reset();
        foreach (m_hist[k]) m_hist[k] = 0;
        m_busy_left = 0;
        m_vld = 0; m_i = 0; m_qu = 0; m_ql = 0; m_ov = 0;
    endtask

    task automatic m_accept(input int d);
        int a, q;
        for (int k = 6; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = d;
        a = -54 * m_hist[0] - 163 * m_hist[2] + 163 * m_hist[4] + 54 * m_hist[6];
        q = sat12(a >>> 8);   // floor division by 256
        p_qu = q;
        p_ql = (q == -2048) ? 2047 : -q;
        p_i  = m_hist[3];
    endtask

    // One clock edge of the model with the inputs presented this cycle
    task automatic m_edge(input logic v, input int d);
        if (rst) begin
            m_reset();
            return;
        end
        m_vld = 0;
        if (m_busy_left > 0) begin
            if (v) m_ov = 1;
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_vld = 1; m_i = p_i; m_qu = p_qu; m_ql = p_ql;
            end
        end else if (v) begin
            m_accept(d);
            m_busy_left = 5;
        end
    endtask

    task automatic check_all();
        chk("busy_u", int'(bus_u.busy), (m_busy_left > 0) ? 1 : 0);
        chk("vld_u",  int'(bus_u.data_out_valid), m_vld);
        chk("i_u",    int'($signed(bus_u.data_out_i)), m_i);
        chk("q_u",    int'($signed(bus_u.data_out_q)), m_qu);
        chk("vld_l",  int'(bus_l.data_out_valid), m_vld);
        chk("i_l",    int'($signed(bus_l.data_out_i)), m_i);
        chk("q_l",    int'($signed(bus_l.data_out_q)), m_ql);
`ifdef SSB_MOD_OVERRUN_EN
        chk("ovr_u",  int'(bus_u.overrun), m_ov);
`endif
    endtask

    task automatic drive(input logic v, input logic [11:0] d);
        bus_u.data_in = d; bus_u.data_in_valid = v;
        bus_l.data_in = d; bus_l.data_in_valid = v;
    endtask

    // One cycle: drive at negedge, model at posedge, check at next negedge
    task automatic cyc(input logic v, input int d);
        drive(v, 12'(d));
        @(posedge clk);
        m_edge(v, d);
        @(negedge clk);
        check_all();
    endtask

    // Offer a sample and idle until the result is out (cycle N+6)
    task automatic feed(input int d);
        cyc(1'b1, d);
        for (int k = 0; k < 5; k++) cyc(1'b0, 0);
    endtask

    int imp_in[7]  = '{1000, 0, 0, 0, 0, 0, 0};
    int imp_qu[7]  = '{-211, 0, -637, 0, 636, 0, 210};
    int imp_i[7]   = '{0, 0, 0, 1000, 0, 0, 0};
    int sat_in[7]  = '{2047, 0, 2047, 0, -2048, 0, -2048};

    initial begin
        drive(1'b0, 12'd0);
        m_reset();
        #2;
        chk("rst_busy", int'(bus_u.busy), 0);
        chk("rst_vld",  int'(bus_u.data_out_valid), 0);
        chk("rst_i",    int'(bus_u.data_out_i), 0);
        chk("rst_q",    int'(bus_u.data_out_q), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 0);

        // impulse through both sidebands
        for (int n = 0; n < 7; n++) begin
            feed(imp_in[n]);
            chk("imp_vld", int'(bus_u.data_out_valid), 1);
            chk("imp_qu", int'($signed(bus_u.data_out_q)), imp_qu[n]);
            chk("imp_ql", int'($signed(bus_l.data_out_q)), -imp_qu[n]);
            chk("imp_i",  int'($signed(bus_u.data_out_i)), imp_i[n]);
        end

        // saturation
        for (int n = 0; n < 7; n++) feed(sat_in[n]);
        chk("sat_qu", int'($signed(bus_u.data_out_q)), 2047);
        chk("sat_ql", int'($signed(bus_l.data_out_q)), -2047);
        chk("sat_i",  int'($signed(bus_u.data_out_i)), 0);

        // async reset with no clock edge: outputs are nonzero beforehand
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(bus_u.busy), 0);
        chk("arst_vld",  int'(bus_u.data_out_valid), 0);
        chk("arst_i",    int'(bus_u.data_out_i), 0);
        chk("arst_q",    int'(bus_u.data_out_q), 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;

        // overrun: valid held 3 cycles, only the first is taken
        cyc(1'b1, 100);
        cyc(1'b1, 200);
        cyc(1'b1, 300);
        for (int k = 0; k < 3; k++) cyc(1'b0, 0);
        chk("ovr_vld", int'(bus_u.data_out_valid), 1);
`ifdef SSB_MOD_OVERRUN_EN
        chk("ovr_flag", int'(bus_u.overrun), 1);
`endif
        cyc(1'b0, 0);

        // fill history so a clear is observable, then reset mid-MAC
        for (int n = 0; n < 7; n++) feed(700 + 50 * n);
        cyc(1'b1, 500);
        cyc(1'b0, 0);
        cyc(1'b0, 0);            // now in cycle N+3
        rst = 1'b1;
        m_reset();
        #1;
        chk("mid_busy", int'(bus_u.busy), 0);
        cyc(1'b0, 0);            // edge with rst held
        rst = 1'b0;
        for (int k = 0; k < 6; k++) cyc(1'b0, 0);  // no stale pulse
        feed(0);
        chk("mid_vld", int'(bus_u.data_out_valid), 1);
        chk("mid_q",   int'($signed(bus_u.data_out_q)), 0);
        chk("mid_i",   int'($signed(bus_u.data_out_i)), 0);

        // random traffic, with occasional sample offered while busy
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 1)), int'($signed(12'($urandom))));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
